// File: rtl/simple_gpu_pkg.sv
// Shared types and helpers for the simple_gpu triangle rasterizer.
// Optional full-screen clear is compiled in with SIMPLE_GPU_CLEAR_EN.
package simple_gpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_DRAW_TRI  = 4'd1,
    OP_SET_COLOR = 4'd2,
    OP_CLEAR     = 4'd3
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VTX,
    ST_SETUP,
    ST_SCAN,
    ST_WRITE,
    ST_DONE
`ifdef SIMPLE_GPU_CLEAR_EN
    , ST_CLEAR
`endif
  } state_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } vertex_t;

  localparam logic [31:0] DEFAULT_COLOR = 32'h00FF_FFFF;

  function automatic logic [15:0] min3(logic [15:0] a, logic [15:0] b, logic [15:0] c);
    logic [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [15:0] max3(logic [15:0] a, logic [15:0] b, logic [15:0] c);
    logic [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Edge function of point p against directed edge a->b, evaluated at 34-bit signed.
  function automatic logic signed [33:0] edge_fn(vertex_t a, vertex_t b,
                                                 logic [15:0] px, logic [15:0] py);
    logic signed [33:0] bax, bay, pax, pay;
    bax = $signed({18'd0, b.x}) - $signed({18'd0, a.x});
    bay = $signed({18'd0, b.y}) - $signed({18'd0, a.y});
    pax = $signed({18'd0, px}) - $signed({18'd0, a.x});
    pay = $signed({18'd0, py}) - $signed({18'd0, a.y});
    return bax * pay - bay * pax;
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pushes while full are dropped.
// Read data is the head entry, valid whenever empty_o is low.
module gpu_cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/simple_gpu.sv
// Command-driven triangle rasterizer writing 32-bit pixels to SDRAM one word at a time.
// Define SIMPLE_GPU_CLEAR_EN to make opcode 3 clear the whole framebuffer.
import simple_gpu_pkg::*;

module simple_gpu #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SCREEN_W   = 320,
  parameter int unsigned SCREEN_H   = 240,
  parameter logic [21:0] FB_BASE    = 22'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fifo_write_data,
  input  logic        fifo_write,
  input  logic        SD_waitrequest,
  output logic        SD_write,
  output logic [31:0] SD_wdata,
  output logic [21:0] SD_address
);

  localparam logic [15:0] X_LAST = 16'(SCREEN_W - 1);
  localparam logic [15:0] Y_LAST = 16'(SCREEN_H - 1);

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;

  state_e      state_q;
  logic [31:0] color_q;
  logic [7:0]  tri_cnt_q;
  logic [1:0]  vtx_idx_q;
  vertex_t     vtx_q [3];
  logic [15:0] bx0_q, bx1_q, by1_q;
  logic [15:0] px_q, py_q;
  logic        sd_write_q;
  logic [31:0] sd_wdata_q;
  logic [21:0] sd_address_q;

`ifdef SIMPLE_GPU_CLEAR_EN
  localparam int unsigned NUM_PIX = SCREEN_W * SCREEN_H;
  localparam int unsigned CLR_W   = $clog2(NUM_PIX);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(NUM_PIX - 1);
  logic [CLR_W-1:0] clr_cnt_q;
`endif

  gpu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_write),
    .wdata_i (fifo_write_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  opcode_e cmd_op;
  vertex_t cmd_vtx;
  assign cmd_op   = opcode_e'(fifo_rdata[31:28]);
  assign cmd_vtx  = vertex_t'(fifo_rdata);
  assign fifo_pop = !fifo_empty && (state_q == ST_IDLE || state_q == ST_VTX);

  logic [15:0]        min_x, max_x, min_y, max_y;
  logic signed [33:0] area, e0, e1, e2;
  logic               off_screen, covered, last_pix;
  logic [15:0]        nxt_px, nxt_py;
  logic [21:0]        pix_addr;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    min_x      = min3(vtx_q[0].x, vtx_q[1].x, vtx_q[2].x);
    min_y      = min3(vtx_q[0].y, vtx_q[1].y, vtx_q[2].y);
    max_x      = max3(vtx_q[0].x, vtx_q[1].x, vtx_q[2].x);
    max_y      = max3(vtx_q[0].y, vtx_q[1].y, vtx_q[2].y);
    area       = edge_fn(vtx_q[0], vtx_q[1], vtx_q[2].x, vtx_q[2].y);
    off_screen = (min_x > X_LAST) || (min_y > Y_LAST);
    if (max_x > X_LAST) max_x = X_LAST;
    if (max_y > Y_LAST) max_y = Y_LAST;

    e0 = edge_fn(vtx_q[0], vtx_q[1], px_q, py_q);
    e1 = edge_fn(vtx_q[1], vtx_q[2], px_q, py_q);
    e2 = edge_fn(vtx_q[2], vtx_q[0], px_q, py_q);
    // Inclusive edges, either winding.
    covered = (e0 >= 34'sd0 && e1 >= 34'sd0 && e2 >= 34'sd0) ||
              (e0 <= 34'sd0 && e1 <= 34'sd0 && e2 <= 34'sd0);

    last_pix = (px_q == bx1_q) && (py_q == by1_q);
    nxt_px   = px_q + 16'd1;
    nxt_py   = py_q;
    if (px_q == bx1_q) begin
      nxt_px = bx0_q;
      nxt_py = py_q + 16'd1;
    end
    pix_addr = 22'(32'(FB_BASE) + 32'(py_q) * SCREEN_W + 32'(px_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      color_q      <= DEFAULT_COLOR;
      tri_cnt_q    <= '0;
      vtx_idx_q    <= '0;
      sd_write_q   <= 1'b0;
      sd_wdata_q   <= '0;
      sd_address_q <= '0;
`ifdef SIMPLE_GPU_CLEAR_EN
      clr_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            case (cmd_op)
              OP_DRAW_TRI: begin
                if (fifo_rdata[7:0] != 8'd0) begin
                  tri_cnt_q <= fifo_rdata[7:0];
                  vtx_idx_q <= '0;
                  state_q   <= ST_VTX;
                end
              end
              OP_SET_COLOR: color_q <= {8'h00, fifo_rdata[23:0]};
`ifdef SIMPLE_GPU_CLEAR_EN
              OP_CLEAR: begin
                clr_cnt_q    <= '0;
                sd_address_q <= FB_BASE;
                sd_wdata_q   <= color_q;
                sd_write_q   <= 1'b1;
                state_q      <= ST_CLEAR;
              end
`endif
              default: ;
            endcase
          end
        end

        ST_VTX: begin
          if (!fifo_empty) begin
            vtx_q[vtx_idx_q] <= cmd_vtx;
            if (vtx_idx_q == 2'd2) state_q <= ST_SETUP;
            else                   vtx_idx_q <= vtx_idx_q + 2'd1;
          end
        end

        ST_SETUP: begin
          if (area == 34'sd0 || off_screen) begin
            state_q <= ST_DONE;
          end else begin
            bx0_q   <= min_x;
            bx1_q   <= max_x;
            by1_q   <= max_y;
            px_q    <= min_x;
            py_q    <= min_y;
            state_q <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (covered) begin
            sd_write_q   <= 1'b1;
            sd_address_q <= pix_addr;
            sd_wdata_q   <= color_q;
            state_q      <= ST_WRITE;
          end else if (last_pix) begin
            state_q <= ST_DONE;
          end else begin
            px_q <= nxt_px;
            py_q <= nxt_py;
          end
        end

        ST_WRITE: begin
          if (!SD_waitrequest) begin
            sd_write_q <= 1'b0;
            if (last_pix) begin
              state_q <= ST_DONE;
            end else begin
              px_q    <= nxt_px;
              py_q    <= nxt_py;
              state_q <= ST_SCAN;
            end
          end
        end

        ST_DONE: begin
          tri_cnt_q <= tri_cnt_q - 8'd1;
          vtx_idx_q <= '0;
          state_q   <= (tri_cnt_q == 8'd1) ? ST_IDLE : ST_VTX;
        end

`ifdef SIMPLE_GPU_CLEAR_EN
        ST_CLEAR: begin
          if (!SD_waitrequest) begin
            if (clr_cnt_q == CLR_LAST) begin
              sd_write_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              clr_cnt_q    <= clr_cnt_q + 1'b1;
              sd_address_q <= sd_address_q + 22'd1;
            end
          end
        end
`endif

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign SD_write   = sd_write_q;
  assign SD_wdata   = sd_wdata_q;
  assign SD_address = sd_address_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_simple_gpu.sv
// Scoreboard bench for simple_gpu: a command-level model predicts every SDRAM write,
// and a negedge monitor compares each accepted write and checks stall stability.
`timescale 1ns/1ps
module tb_simple_gpu;

  localparam int W = 320;
  localparam int H = 240;
  localparam logic [31:0] DEF_COLOR = 32'h00FF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fifo_write_data;
  logic        fifo_write;
  logic        SD_waitrequest;
  logic        SD_write;
  logic [31:0] SD_wdata;
  logic [21:0] SD_address;

  simple_gpu dut (
    .clk             (clk),
    .reset           (reset),
    .fifo_write_data (fifo_write_data),
    .fifo_write      (fifo_write),
    .SD_waitrequest  (SD_waitrequest),
    .SD_write        (SD_write),
    .SD_wdata        (SD_wdata),
    .SD_address      (SD_address)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  stall_mode = 0;   // 0 none, 1 random, 2 three cycles per write, 3 always
  int  wr_count = 0;
  int  mark_count = 0;
  logic [21:0] first_addr, last_addr;
  logic [31:0] first_data, last_data;

  // Reference model state: colour, pending triangles, collected vertices.
  logic [31:0] m_color;
  int m_tris_left, m_vcnt;
  int mvx[3], mvy[3];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint edge_v(int ax, int ay, int bx, int by, int px, int py);
    return longint'(bx - ax) * longint'(py - ay) - longint'(by - ay) * longint'(px - ax);
  endfunction

  function automatic void model_tri(int ax, int ay, int bx, int by, int cx, int cy);
    longint e0, e1, e2;
    int x0, x1, y0, y1;
    if (edge_v(ax, ay, bx, by, cx, cy) == 0) return;
    x0 = ax; if (bx < x0) x0 = bx; if (cx < x0) x0 = cx;
    y0 = ay; if (by < y0) y0 = by; if (cy < y0) y0 = cy;
    x1 = ax; if (bx > x1) x1 = bx; if (cx > x1) x1 = cx;
    y1 = ay; if (by > y1) y1 = by; if (cy > y1) y1 = cy;
    if (x0 >= W || y0 >= H) return;
    if (x1 > W - 1) x1 = W - 1;
    if (y1 > H - 1) y1 = H - 1;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        e0 = edge_v(ax, ay, bx, by, x, y);
        e1 = edge_v(bx, by, cx, cy, x, y);
        e2 = edge_v(cx, cy, ax, ay, x, y);
        if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
          exp_q.push_back('{addr: 22'(y * W + x), data: m_color});
      end
    end
  endfunction

  function automatic void model_word(logic [31:0] w);
    if (m_tris_left > 0) begin
      mvx[m_vcnt] = int'(w[31:16]);
      mvy[m_vcnt] = int'(w[15:0]);
      m_vcnt++;
      if (m_vcnt == 3) begin
        model_tri(mvx[0], mvy[0], mvx[1], mvy[1], mvx[2], mvy[2]);
        m_vcnt = 0;
        m_tris_left--;
      end
    end else begin
      case (w[31:28])
        4'd1: m_tris_left = int'(w[7:0]);
        4'd2: m_color = {8'h00, w[23:0]};
`ifdef SIMPLE_GPU_CLEAR_EN
        4'd3: for (int i = 0; i < W * H; i++) exp_q.push_back('{addr: 22'(i), data: m_color});
`endif
        default: ;
      endcase
    end
  endfunction

  function automatic void model_reset();
    m_color     = DEF_COLOR;
    m_tris_left = 0;
    m_vcnt      = 0;
  endfunction

  task automatic push_word(logic [31:0] w, bit accepted = 1'b1);
    fifo_write      = 1'b1;
    fifo_write_data = w;
    @(posedge clk); #1;
    fifo_write      = 1'b0;
    if (accepted) model_word(w);
  endtask

  function automatic logic [31:0] vtx(int x, int y);
    return {16'(x), 16'(y)};
  endfunction

  task automatic wait_drain(string name, int budget, int tail);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (tail) @(posedge clk);
    #1;
  endtask

  // SD_waitrequest driver.
  initial begin : wr_drv
    int stall_cnt;
    stall_cnt = 0;
    SD_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (stall_mode)
        0: SD_waitrequest = 1'b0;
        1: SD_waitrequest = ($urandom_range(0, 3) == 0);
        2: begin
          if (SD_write && stall_cnt < 3) begin
            SD_waitrequest = 1'b1;
            stall_cnt++;
          end else begin
            SD_waitrequest = 1'b0;
            stall_cnt = 0;
          end
        end
        default: SD_waitrequest = 1'b1;
      endcase
    end
  end

  // Monitor: compares each accepted write and checks hold behaviour under stall.
  logic        hold_v = 1'b0;
  logic [21:0] hold_a;
  logic [31:0] hold_d;
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_write_held", 64'(SD_write), 64'd1);
        check("stall_addr_stable", 64'(SD_address), 64'(hold_a));
        check("stall_data_stable", 64'(SD_wdata), 64'(hold_d));
      end
      hold_v = 1'b0;
      if (SD_write && SD_waitrequest) begin
        hold_v = 1'b1;
        hold_a = SD_address;
        hold_d = SD_wdata;
      end else if (SD_write) begin
        if (wr_count == mark_count) begin
          first_addr = SD_address;
          first_data = SD_wdata;
        end
        last_addr = SD_address;
        last_data = SD_wdata;
        wr_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                   SD_address, SD_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(SD_address), 64'(e.addr));
          check("wr_data", 64'(SD_wdata), 64'(e.data));
        end
      end
    end
  end

  localparam logic [31:0] OVF [20] = '{
    32'h2011_2233, 32'h1000_0001, 32'h0004_0004, 32'h0006_0004, 32'h0004_0006,
    32'h2044_5566, 32'h1000_0001, 32'h000A_000A, 32'h000C_000A, 32'h000A_000C,
    32'h0000_0000, 32'h5000_0000, 32'hF000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h2000_DEAD, 32'h2000_DEAD, 32'h2000_DEAD, 32'h2000_DEAD
  };

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    reset           = 1'b1;
    fifo_write      = 1'b0;
    fifo_write_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sd_write", 64'(SD_write), 64'd0);
    check("reset_sd_addr", 64'(SD_address), 64'd0);
    check("reset_sd_wdata", 64'(SD_wdata), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Two triangles in one DRAW_TRI command.
    stall_mode = 0;
    mark_count = wr_count;
    push_word(32'h1000_0002);
    push_word(vtx(30, 100)); push_word(vtx(130, 100)); push_word(vtx(30, 0));
    push_word(vtx(20, 10));  push_word(vtx(30, 10));   push_word(vtx(20, 20));
    wait_drain("tri_pair", 25000, 20);
    check("tri_pair_count", 64'(wr_count - mark_count), 64'd5217);
    check("tri_pair_first_addr", 64'(first_addr), 64'd30);
    check("tri_pair_first_data", 64'(first_data), 64'(DEF_COLOR));
    check("tri_pair_last_addr", 64'(last_addr), 64'd6420);

    // SET_COLOR 0 followed by words that must parse as NOPs.
    mark_count = wr_count;
    push_word(32'h2000_0000);
    push_word(32'h0122_0000);
    push_word(32'h0082_00A0);
`ifndef SIMPLE_GPU_CLEAR_EN
    push_word(32'h3000_0000);
`endif
    wait_drain("nops", 100, 20);
    check("nops_no_writes", 64'(wr_count - mark_count), 64'd0);

    // Small triangle with three stall cycles on every write.
    stall_mode = 2;
    mark_count = wr_count;
    push_word(32'h2000_00AB);
    push_word(32'h1000_0001);
    push_word(vtx(0, 0)); push_word(vtx(2, 0)); push_word(vtx(0, 2));
    wait_drain("stalled_tri", 500, 10);
    check("stalled_tri_count", 64'(wr_count - mark_count), 64'd6);
    check("stalled_tri_last_addr", 64'(last_addr), 64'd640);

    // Degenerate triangle and a zero-count DRAW_TRI produce nothing.
    stall_mode = 0;
    mark_count = wr_count;
    push_word(32'h1000_0001);
    push_word(vtx(0, 0)); push_word(vtx(5, 5)); push_word(vtx(10, 10));
    push_word(32'h1000_0000);
    wait_drain("degenerate", 100, 50);
    check("degenerate_no_writes", 64'(wr_count - mark_count), 64'd0);

    // FIFO overflow while the write port is stalled.
    stall_mode = 3;
    push_word(32'h1000_0001);
    push_word(vtx(0, 0)); push_word(vtx(2, 0)); push_word(vtx(0, 2));
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) push_word(OVF[i], i < 16);
    stall_mode = 1;
    wait_drain("overflow", 3000, 30);
    mark_count = wr_count;
    push_word(32'h1000_0001);
    push_word(vtx(50, 50)); push_word(vtx(52, 50)); push_word(vtx(50, 52));
    wait_drain("after_overflow", 500, 20);
    check("after_overflow_colour", 64'(last_data), 64'h0044_5566);

    // Randomized triangles, colours and stalls, including off-screen clamps.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) push_word({8'h20, 24'($urandom)});
      if ($urandom_range(0, 5) == 0) push_word(32'h1000_0000);
      base = $urandom_range(1, 2);
      push_word({28'h1000_000, 4'(base)});
      for (int t = 0; t < base; t++) begin
        int bx, by;
        bx = $urandom_range(0, 330);
        by = $urandom_range(0, 250);
        for (int v = 0; v < 3; v++)
          push_word(vtx(bx + $urandom_range(0, 12), by + $urandom_range(0, 12)));
      end
      wait_drain("random", 3000, 200);
    end

    // Reset while a large triangle is scanning, with more commands still queued.
    stall_mode = 0;
    push_word(32'h1000_0001);
    push_word(vtx(0, 0)); push_word(vtx(200, 0)); push_word(vtx(0, 150));
    push_word(32'h2000_0777, 1'b0);
    push_word(32'h1000_0001, 1'b0);
    push_word(vtx(1, 1), 1'b0); push_word(vtx(3, 1), 1'b0); push_word(vtx(1, 3), 1'b0);
    repeat (300) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midscan_reset_sd_write", 64'(SD_write), 64'd0);
    check("midscan_reset_sd_addr", 64'(SD_address), 64'd0);
    check("midscan_reset_sd_wdata", 64'(SD_wdata), 64'd0);
    @(posedge clk); #1;
    mark_count = wr_count;
    push_word(32'h1000_0001);
    push_word(vtx(7, 7)); push_word(vtx(9, 7)); push_word(vtx(7, 9));
    wait_drain("post_reset", 500, 100);
    check("post_reset_count", 64'(wr_count - mark_count), 64'd6);
    check("post_reset_colour", 64'(first_data), 64'(DEF_COLOR));
    check("post_reset_first_addr", 64'(first_addr), 64'(7 * W + 7));

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
